// File: rtl/sdram_avmm_resp_pkg.sv
// Shared types and helpers for the Avalon-MM SDRAM responder.
package sdram_avmm_pkg;

  localparam int SDRAM_DATA_W  = 128;
  localparam int SDRAM_BE_W    = SDRAM_DATA_W / 8;
  localparam int SDRAM_BURST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_ISSUE
  } avmm_st_t;

  // Byte address to word address: drop the byte-lane offset bits.
  function automatic logic [31:0] byte2word(input logic [31:0] byte_addr,
                                            input int unsigned lsb);
    return byte_addr >> lsb;
  endfunction

endpackage

// File: rtl/sdram_avmm_resp_if.sv
// Avalon-MM command/response bundle between the load/store engine and the responder.
interface sdram_avmm_resp_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 8
);

  logic [ADDR_W-1:0]   avs_address;
  logic                avs_read;
  logic                avs_write;
  logic [DATA_W-1:0]   avs_writedata;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic [BURST_W-1:0]  avs_burstcount;
  logic                avs_waitrequest;
  logic [DATA_W-1:0]   avs_readdata;
  logic                avs_readdatavalid;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

endinterface

// File: rtl/sdram_avmm_resp_rd_lat_pipe.sv
// Read-return delay line: tracks which RAM output cycles carry requested data
// and registers that data onto the Avalon read-response bus.
module rd_lat_pipe #(
  parameter int DATA_W = 128,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] rdata,
  output logic              rvld
);

  logic [STAGES-1:0] vld_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              rvld_p1;

  // Valid shift register; its last stage lines up with the RAM's read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
    end else begin
      vld_p0[0] <= vld_in;
      for (int i = 1; i < STAGES; i++) begin
        vld_p0[i] <= vld_p0[i-1];
      end
    end
  end

  // Output register: capture RAM data on its valid cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvld_p1  <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      rvld_p1 <= vld_p0[STAGES-1];
      if (vld_p0[STAGES-1]) begin
        rdata_p1 <= d_in;
      end
    end
  end

  assign rdata = rdata_p1;
  assign rvld  = rvld_p1;

endmodule

// File: rtl/sdram_avmm_resp.sv
// Avalon-MM burst responder in front of a fixed-latency word-wide RAM.
// Writes go straight through to the RAM in the accept cycle; reads are
// issued one word per cycle with waitrequest held, and the data returns
// through rd_lat_pipe in order without back-pressure.
module sdram_avmm_resp
  import sdram_avmm_pkg::*;
#(
  parameter int DATA_W  = SDRAM_DATA_W,
  parameter int ADDR_W  = 32,
  parameter int MEM_AW  = 12,
  parameter int BURST_W = SDRAM_BURST_W,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  sdram_avmm_resp_if.slave    avs,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_d,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_q,
  output logic                proto_err
);

  localparam int unsigned LSB = $clog2(DATA_W / 8);

  avmm_st_t           state, state_nxt;
  logic [MEM_AW-1:0]  addr_q, addr_nxt;
  logic [BURST_W-1:0] rem_q, rem_nxt;
  logic               proto_err_q, proto_err_nxt;

  logic [ADDR_W-1:0]  cmd_byte;
  logic [MEM_AW-1:0]  cmd_word;
  logic [BURST_W-1:0] cmd_bc;

  assign cmd_byte = avs.avs_address;
  assign cmd_word = MEM_AW'(byte2word(32'(cmd_byte), LSB));
  // A burstcount of zero is served as a single beat.
  assign cmd_bc   = (avs.avs_burstcount == '0) ? BURST_W'(1) : avs.avs_burstcount;

  // Control state: FSM, running word address, beats remaining, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      rem_q       <= rem_nxt;
      proto_err_q <= proto_err_nxt;
    end
  end

  // Next state, RAM strobes and waitrequest; outputs are forced quiet while rst is high.
  always_comb begin
    state_nxt           = state;
    addr_nxt            = addr_q;
    rem_nxt             = rem_q;
    proto_err_nxt       = proto_err_q;
    avs.avs_waitrequest = 1'b0;
    mem_addr            = addr_q;
    mem_we              = 1'b0;
    mem_be              = avs.avs_byteenable;
    mem_d               = avs.avs_writedata;
    mem_re              = 1'b0;

    if (rst) begin
      avs.avs_waitrequest = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (avs.avs_write) begin
            // Beat 0 of a write; a simultaneous read is dropped and flagged.
            mem_we    = 1'b1;
            mem_addr  = cmd_word;
            addr_nxt  = cmd_word + MEM_AW'(1);
            rem_nxt   = cmd_bc - BURST_W'(1);
            if (cmd_bc != BURST_W'(1)) begin
              state_nxt = ST_WR_BURST;
            end
            if (avs.avs_read) begin
              proto_err_nxt = 1'b1;
            end
          end else if (avs.avs_read) begin
            addr_nxt  = cmd_word;
            rem_nxt   = cmd_bc;
            state_nxt = ST_RD_ISSUE;
          end
        end

        ST_WR_BURST: begin
          if (avs.avs_read) begin
            proto_err_nxt = 1'b1;
          end
          if (avs.avs_write) begin
            mem_we   = 1'b1;
            addr_nxt = addr_q + MEM_AW'(1);
            rem_nxt  = rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1)) begin
              state_nxt = ST_IDLE;
            end
          end
        end

        ST_RD_ISSUE: begin
          avs.avs_waitrequest = 1'b1;
          mem_re   = 1'b1;
          addr_nxt = addr_q + MEM_AW'(1);
          rem_nxt  = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign proto_err = proto_err_q;

  rd_lat_pipe #(
    .DATA_W (DATA_W),
    .STAGES (MEM_LAT)
  ) u_rd_lat_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_in (mem_re),
    .d_in   (mem_q),
    .rdata  (avs.avs_readdata),
    .rvld   (avs.avs_readdatavalid)
  );

endmodule

// File: tb/tb_sdram_avmm_resp.sv
// Scoreboard bench for sdram_avmm_resp with a behavioural RAM and reference memory.
module tb_sdram_avmm_resp;
  import sdram_avmm_pkg::*;

  localparam int DATA_W    = 128;
  localparam int ADDR_W    = 32;
  localparam int MEM_AW    = 12;
  localparam int BURST_W   = 8;
  localparam int MEM_LAT   = 2;
  localparam int BE_W      = DATA_W / 8;
  localparam int MEM_WORDS = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_avmm_resp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) avs ();

  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we, mem_re, proto_err;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_d, mem_q;

  sdram_avmm_resp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BURST_W(BURST_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .avs(avs),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_d(mem_d),
    .mem_re(mem_re), .mem_q(mem_q), .proto_err(proto_err)
  );

  // Behavioural backing RAM: byte-masked writes, MEM_LAT-cycle reads, junk when idle.
  logic [DATA_W-1:0] ram [MEM_WORDS];
  logic [DATA_W-1:0] ram_pipe [MEM_LAT];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < BE_W; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_d[8*b +: 8];
    ram_pipe[0] <= mem_re ? ram[mem_addr] : {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 1; i < MEM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign mem_q = ram_pipe[MEM_LAT-1];

  // Reference model and scoreboard queues.
  typedef struct packed {
    logic [MEM_AW-1:0] a;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  wr_t               wq[$];
  logic [MEM_AW-1:0] raq[$];
  logic [DATA_W-1:0] rdq[$];
  int                stampq[$];
  logic [DATA_W-1:0] wdat [16];
  logic [BE_W-1:0]   wbe  [16];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event occurred where none was expected", nm);
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                              input logic [DATA_W-1:0] nd,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_d;
    for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  // Monitor: pops and compares whenever the DUT strobes the RAM or returns read data.
  always @(negedge clk) begin
    wr_t e;
    int  s;
    if (!rst) begin
      if (mem_we) begin
        if (wq.size() == 0) fail("unexpected_mem_we");
        else begin
          e = wq.pop_front();
          chk("wr_addr", DATA_W'(mem_addr), DATA_W'(e.a));
          chk("wr_be",   DATA_W'(mem_be),   DATA_W'(e.be));
          chk("wr_data", mem_d, e.d);
        end
      end
      if (mem_re) begin
        if (raq.size() == 0) fail("unexpected_mem_re");
        else chk("rd_addr", DATA_W'(mem_addr), DATA_W'(raq.pop_front()));
        stampq.push_back(cyc);
      end
      if (avs.avs_readdatavalid) begin
        if (rdq.size() == 0) fail("unexpected_readdatavalid");
        else chk("rd_data", avs.avs_readdata, rdq.pop_front());
        if (stampq.size() != 0) begin
          s = stampq.pop_front();
          chk("rd_latency", DATA_W'(cyc - s), DATA_W'(MEM_LAT + 1));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!avs.avs_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("accept_timeout");
  endtask

  task automatic wr_burst(input logic [31:0] baddr, input int bc, input int gap_at,
                          input int gap_len, input bit also_read);
    int n;
    bit ok;
    logic [MEM_AW-1:0] w;
    n = (bc == 0) ? 1 : bc;
    w = MEM_AW'(baddr >> 4);
    for (int i = 0; i < n; i++) begin
      avs.avs_write      = 1'b1;
      avs.avs_read       = (i == 0) && also_read;
      avs.avs_address    = (i == 0) ? baddr : $urandom();
      avs.avs_burstcount = (i == 0) ? BURST_W'(bc) : BURST_W'($urandom_range(0, 255));
      avs.avs_writedata  = wdat[i];
      avs.avs_byteenable = wbe[i];
      wq.push_back('{a: w, be: wbe[i], d: wdat[i]});
      ref_mem[w] = merge(ref_mem[w], wdat[i], wbe[i]);
      w = w + MEM_AW'(1);
      wait_accept(ok);
      if (!ok) return;
      chk("wr_we_in_accept_cycle", DATA_W'(mem_we), DATA_W'(1));
      step();
      avs.avs_write = 1'b0;
      avs.avs_read  = 1'b0;
      if (i == gap_at) repeat (gap_len) step();
    end
  endtask

  task automatic rd_burst(input logic [31:0] baddr, input int bc);
    int n, cnt;
    bit ok;
    logic [MEM_AW-1:0] w;
    n = (bc == 0) ? 1 : bc;
    w = MEM_AW'(baddr >> 4);
    avs.avs_read       = 1'b1;
    avs.avs_write      = 1'b0;
    avs.avs_address    = baddr;
    avs.avs_burstcount = BURST_W'(bc);
    for (int i = 0; i < n; i++) begin
      raq.push_back(w);
      rdq.push_back(ref_mem[w]);
      w = w + MEM_AW'(1);
    end
    wait_accept(ok);
    if (!ok) return;
    step();
    avs.avs_read = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (avs.avs_waitrequest) cnt++;
      else break;
    end
    chk("rd_issue_waitrequest_cycles", DATA_W'(cnt), DATA_W'(n));
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (rdq.size() == 0 && wq.size() == 0 && raq.size() == 0) break;
      step();
    end
    repeat (4) step();
    chk("drain_rd_pending", DATA_W'(rdq.size()), DATA_W'(0));
    chk("drain_wr_pending", DATA_W'(wq.size()), DATA_W'(0));
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int word;
    bit ok;
    logic [31:0] ba;

    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    avs.avs_read = 1'b0; avs.avs_write = 1'b0; avs.avs_address = '0;
    avs.avs_writedata = '0; avs.avs_byteenable = '0; avs.avs_burstcount = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", DATA_W'(avs.avs_waitrequest), DATA_W'(1));
    chk("rst_rdvalid",     DATA_W'(avs.avs_readdatavalid), DATA_W'(0));
    chk("rst_readdata",    avs.avs_readdata, '0);
    chk("rst_mem_we",      DATA_W'(mem_we), DATA_W'(0));
    chk("rst_mem_re",      DATA_W'(mem_re), DATA_W'(0));
    chk("rst_proto_err",   DATA_W'(proto_err), DATA_W'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_waitrequest", DATA_W'(avs.avs_waitrequest), DATA_W'(0));
    step();

    // Single write then single read at 0x40
    wdat[0] = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    wbe[0]  = '1;
    wr_burst(32'h40, 1, -1, 0, 1'b0);
    rd_burst(32'h40, 1);
    drain();

    // Four-beat write burst at 0x100 with an idle gap after beat 1, then read back
    for (int i = 0; i < 4; i++) begin wdat[i] = rnd128(); wbe[i] = '1; end
    wr_burst(32'h100, 4, 1, 1, 1'b0);
    rd_burst(32'h100, 4);
    drain();

    // Byte-enable merge over a zeroed word
    wdat[0] = '0; wbe[0] = '1;
    wr_burst(32'h200, 1, -1, 0, 1'b0);
    wdat[0] = {{15{8'hA5}}, 8'hFF}; wbe[0] = 16'h0001;
    wr_burst(32'h200, 1, -1, 0, 1'b0);
    rd_burst(32'h200, 1);
    drain();

    // Address wrap for writes and reads; burstcount 0 read
    for (int i = 0; i < 3; i++) begin wdat[i] = rnd128(); wbe[i] = '1; end
    wr_burst(32'((MEM_WORDS - 1) * 16), 3, -1, 0, 1'b0);
    rd_burst(32'((MEM_WORDS - 1) * 16), 3);
    rd_burst(32'h40, 0);
    drain();

    // Randomized mixed traffic
    for (int it = 0; it < 40; it++) begin
      word = ($urandom_range(0, 3) == 0) ? (MEM_WORDS - 1 - $urandom_range(0, 3)) : $urandom_range(0, 15);
      ba = (32'(word) << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 4; i++) begin wdat[i] = rnd128(); wbe[i] = BE_W'($urandom()); end
        wr_burst(ba, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      end else begin
        rd_burst(ba, $urandom_range(0, 5));
      end
    end
    drain();

    // Simultaneous read and write: write wins, error is flagged and sticks
    wdat[0] = rnd128(); wbe[0] = '1;
    wr_burst(32'h300, 1, -1, 0, 1'b1);
    @(negedge clk);
    chk("proto_err_set", DATA_W'(proto_err), DATA_W'(1));
    step();
    drain();
    rd_burst(32'h300, 1);
    drain();
    chk("proto_err_sticky", DATA_W'(proto_err), DATA_W'(1));

    // Reset in the middle of an 8-beat read after three RAM reads
    avs.avs_read = 1'b1; avs.avs_address = 32'h400; avs.avs_burstcount = 8'd8;
    for (int i = 0; i < 8; i++) begin
      raq.push_back(MEM_AW'(32'h40 + i));
      rdq.push_back(ref_mem[32'h40 + i]);
    end
    wait_accept(ok);
    step();
    avs.avs_read = 1'b0;
    k = 0;
    for (int i = 0; i < 50 && k < 3; i++) begin
      @(negedge clk);
      if (mem_re) k++;
    end
    chk("mid_burst_mem_re_seen", DATA_W'(k), DATA_W'(3));
    step();
    rst = 1'b1;
    raq.delete(); rdq.delete(); stampq.delete(); wq.delete();
    @(negedge clk);
    chk("mid_rst_waitrequest", DATA_W'(avs.avs_waitrequest), DATA_W'(1));
    chk("mid_rst_mem_re", DATA_W'(mem_re), DATA_W'(0));
    step();
    @(negedge clk);
    chk("mid_rst_rdvalid", DATA_W'(avs.avs_readdatavalid), DATA_W'(0));
    chk("mid_rst_readdata", avs.avs_readdata, '0);
    chk("mid_rst_proto_err", DATA_W'(proto_err), DATA_W'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_waitrequest", DATA_W'(avs.avs_waitrequest), DATA_W'(0));
    step();
    repeat (10) step();

    // Back in IDLE: normal traffic works again
    wdat[0] = rnd128(); wbe[0] = '1;
    wr_burst(32'h500, 1, -1, 0, 1'b0);
    rd_burst(32'h500, 1);
    drain();
    chk("final_proto_err", DATA_W'(proto_err), DATA_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_avmm_resp.md
Name: sdram_avmm_resp

Overview:
- Avalon-MM slave (responder) fronting a simple synchronous word-wide RAM (on-chip SDRAM stand-in / backing store).
- Serves the burst load/store traffic that the register-file load/store engine initiates on its SDRAM interface.
- Accepts pipelined burst reads and writes, maps byte addresses to word addresses and returns read data after a fixed, parameterised memory latency.

Parameters:
- DATA_W, 128, Avalon data width in bits (one SDRAM word).
- ADDR_W, 32, Avalon byte-address width.
- MEM_AW, 12, word-address width of the backing RAM (MEM_WORDS = 2**MEM_AW).
- BURST_W, 8, burstcount width.
- MEM_LAT, 2, backing-RAM read latency in cycles (legal 1..4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- avs_address  in  ADDR_W  byte address of the first beat; low log2(DATA_W/8) bits ignored
- avs_read  in  1  read command
- avs_write  in  1  write beat
- avs_writedata  in  DATA_W  write data
- avs_byteenable  in  DATA_W/8  per-byte write enable
- avs_burstcount  in  BURST_W  beats in burst; sampled on first beat only
- avs_waitrequest  out  1  command/beat not accepted this cycle
- avs_readdata  out  DATA_W  read data
- avs_readdatavalid  out  1  avs_readdata valid
- mem_addr  out  MEM_AW  RAM word address
- mem_we  out  1  RAM write strobe
- mem_be  out  DATA_W/8  RAM byte enables
- mem_d  out  DATA_W  RAM write data
- mem_re  out  1  RAM read strobe
- mem_q  in  DATA_W  RAM read data, valid MEM_LAT cycles after mem_re
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Outputs: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, mem_we=0, mem_re=0, proto_err=0.
  - FSM goes to IDLE; beat counters and in-flight read pipeline are cleared.
  - A burst interrupted by reset is abandoned. No readdatavalid is produced for it after reset.
- The first cycle after reset deasserts: avs_waitrequest=0.
- Word address = avs_address[MEM_AW+3:4] for DATA_W=128. Increments by 1 per beat and wraps modulo MEM_WORDS.
- burstcount 0 is treated as 1.
- FSM states:
  - IDLE, waitrequest=0:
    - avs_write: accept beat 0. Drive mem_we/mem_be/mem_d/mem_addr combinationally in the same cycle. Latch next address and remaining = burstcount-1. Go to WR_BURST if remaining>0, else stay in IDLE.
    - avs_read: latch address and remaining = burstcount. Go to RD_ISSUE. The command is accepted this cycle.
    - avs_read && avs_write together: the write wins, the read is dropped and proto_err is set.
  - WR_BURST, waitrequest=0:
    - Each avs_write cycle is one beat to the next address; decrement remaining.
    - Cycles with avs_write=0 are idle gaps, with no timeout.
    - Return to IDLE on the last beat.
    - avs_read asserted in this state sets proto_err and is ignored.
  - RD_ISSUE, waitrequest=1:
    - Issue one mem_re per cycle, addresses consecutive.
    - Return to IDLE in the cycle after the last mem_re. A new command can be accepted there.
- Read return:
  - Data goes through a MEM_LAT-deep valid shift register aligned to mem_q.
  - avs_readdatavalid is registered and asserts MEM_LAT+1 cycles after the corresponding mem_re.
  - Beats return in order with no gaps for a burst; there is no back-pressure.
  - A new read may be accepted while a previous burst's data is still in flight. Returns stay in order with no overlap, because issue is serialized.
- Write-then-read to the same address in consecutive commands returns the new data (the RAM write precedes the read issue).
- proto_err clears only on rst.

Decomposition:
- Package sdram_avmm_pkg:
  - SDRAM_DATA_W=128, SDRAM_BE_W=16, SDRAM_BURST_W=8.
  - State enum avmm_st_t {ST_IDLE, ST_WR_BURST, ST_RD_ISSUE}.
  - Function byte2word().
- One sub-module, rd_lat_pipe: a parameterised MEM_LAT valid delay line plus output data register, with synchronous clear on rst.

Test Plan:
- Single write addr 0x40, be=0xFFFF, data A, then single read 0x40 -> mem_we at word 4 in accept cycle; readdatavalid exactly MEM_LAT+1 cycles after mem_re with readdata=A.
- Write burst 4 beats at 0x100 with one idle gap after beat 1, then read burst 4 -> words 0x10..0x13 written in order; 4 contiguous readdatavalid beats returning the data in order; waitrequest=1 for 4 cycles during issue.
- Byte-enable write be=0x0001 data 0xFF over word of all 0x00 -> readback low byte 0xFF, other 15 bytes 0x00.
- Read burst 3 starting at last word (MEM_WORDS-1) -> addresses MEM_WORDS-1, 0, 1; burstcount=0 read -> exactly one beat returned.
- avs_read&&avs_write same cycle -> write performed, no readdatavalid, proto_err=1 and stays until rst.
- rst asserted mid read burst 8 after 3 mem_re -> no further readdatavalid; waitrequest=1 during rst, 0 next cycle; FSM in IDLE; proto_err=0.
